fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ram_data  input  32  instruction word returned by RAM one cycle after fetch_req.
REQ-004 SHALL have port: branch_valid  input  1  redirect request, sampled only in EXEC.
REQ-005 SHALL have port: branch_target  input  16  redirect address.
REQ-006 SHALL have port: fetch_addr  output  16  RAM address for instruction fetch; equals pc.
REQ-007 SHALL have port: fetch_req  output  1  high only in FETCH; memory controller owns RAM otherwise.
REQ-008 SHALL have port: instr  output  32  captured instruction register.
REQ-009 SHALL have port: instr_valid  output  1  instr/opcode valid for execute and memory stages.
REQ-010 SHALL have port: opcode  output  4  instr[31:28], feeds memory controller.
REQ-011 SHALL have port: halted  output  1  high in HALT.

Function
REQ-012 SHALL implement states IDLE, FETCH, WAIT, EXEC, MEM, HALT.
REQ-013 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-014 FETCH SHALL assert fetch_req with fetch_addr=pc for one cycle, then go to WAIT.
REQ-015 WAIT SHALL load instr from ram_data at its end, then go to EXEC.
REQ-016 EXEC SHALL assert instr_valid for one cycle.
REQ-017 From EXEC, opcode 4'b1101 (LDR) or 4'b1110 (STR) SHALL go to MEM; 4'b1111 SHALL go to HALT; all others to FETCH.
REQ-018 MEM SHALL hold instr, opcode and instr_valid=1 for one further cycle with fetch_req=0, then go to FETCH.
REQ-019 On leaving EXEC, pc SHALL become branch_target if branch_valid=1, else pc+1 (16-bit, 0xFFFF wraps to 0x0000).
REQ-020 branch_valid outside EXEC SHALL be ignored and SHALL NOT alter pc.
REQ-021 HALT SHALL keep instr_valid=0, fetch_req=0, pc frozen, halted=1 until reset.
REQ-022 Instruction latency SHALL be 3 cycles FETCH-to-EXEC; throughput one instruction per 3 cycles (4 for LDR/STR).
REQ-023 opcode SHALL be combinationally instr[31:28] at all times.

Reset
REQ-024 reset_n low SHALL asynchronously force state=IDLE, pc=0x0000, instr=0, instr_valid=0, fetch_req=0, halted=0.
REQ-025 Reset asserted mid-fetch or in MEM SHALL abandon the instruction; no partial instr shall be presented after release.
REQ-026 Outputs SHALL hold reset values through the IDLE cycle.

Structure
REQ-027 Shared package processor_pkg SHALL hold OP_LDR=4'b1101, OP_STR=4'b1110, OP_HALT=4'b1111, RESET_VECTOR=16'h0000 and the fetch state enum.
REQ-028 pc SHALL live in sub-module pc_reg (load, increment, async reset); FSM and instr register in fetch_unit.

Verification
REQ-029 Reset release, ram_data=32'h1000_0000 -> fetch_req cycle 2 with fetch_addr=0x0000, instr_valid cycle 4, next fetch_addr=0x0001.
REQ-030 EXEC with instr=32'hD000_0000 (LDR) -> instr_valid high 2 cycles, fetch_req low both, next fetch at pc+1.
REQ-031 EXEC with branch_valid=1, branch_target=0x0040 -> next fetch_addr=0x0040; branch_valid pulse in WAIT -> no effect.
REQ-032 pc=0xFFFF, non-branch non-memory instr -> next fetch_addr=0x0000.
REQ-033 instr=32'hF000_0000 -> halted=1, fetch_req stays 0 for 20 cycles; reset_n pulse -> fetch restarts at 0x0000.
REQ-034 reset_n low asynchronously during WAIT -> instr_valid=0 immediately, instr=0, no EXEC before next full fetch.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: bus widths, memory/halt opcodes, reset vector
// and the instruction fetch state encoding.
package processor_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0]   OP_LDR       = 4'b1101;
  localparam logic [OP_W-1:0]   OP_STR       = 4'b1110;
  localparam logic [OP_W-1:0]   OP_HALT      = 4'b1111;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_MEM   = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

  // LDR/STR hand the RAM to the memory controller for one extra cycle.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset to the reset vector, load for redirects,
// 16-bit wrapping increment otherwise.
module pc_reg
  import processor_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: FETCH/WAIT/EXEC loop with an optional MEM
// cycle for loads/stores, and a sticky HALT left only through reset.
module fetch_unit
  import processor_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_req,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [OP_W-1:0]   opcode,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fetch_req_q, fetch_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic [OP_W-1:0]   cur_op;

  assign cur_op = instr_q[DATA_W-1 -: OP_W];

  pc_reg u_pc_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (branch_target),
    .pc        (pc)
  );

  // Next state, instruction capture and pc update; branch only honoured in EXEC.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        instr_d = ram_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_load = branch_valid;
        pc_inc  = !branch_valid;
        if (is_mem_op(cur_op)) begin
          state_d = ST_MEM;
        end else if (cur_op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM:  state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered against the state being entered.
    fetch_req_d   = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_EXEC) || (state_d == ST_MEM);
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      fetch_req_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      fetch_req_q   <= fetch_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign fetch_addr  = pc;
  assign fetch_req   = fetch_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = cur_op;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-level reference model expanded into an
// expected per-cycle script, with random instructions, branches and bus noise.
module tb_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] ram_data;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic [15:0] fetch_addr;
  logic        fetch_req;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic        halted;

  fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ram_data      (ram_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .fetch_addr    (fetch_addr),
    .fetch_req     (fetch_req),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .halted        (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] ram;
    logic        bv;
    logic [15:0] bt;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [31:0] ins;
    logic        halt;
  } cyc_t;

  cyc_t        script[$];
  logic [15:0] m_pc;
  logic [31:0] m_instr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_no  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:28] == 4'hF) w[31:28] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic push(input logic [31:0] ram, input logic bv, input logic [15:0] bt,
                      input logic req, input logic valid, input logic [31:0] ins,
                      input logic halt);
    cyc_t c;
    c.ram = ram; c.bv = bv; c.bt = bt;
    c.req = req; c.addr = m_pc; c.valid = valid; c.ins = ins; c.halt = halt;
    script.push_back(c);
  endtask

  task automatic gen_idle();
    push($urandom, 1'($urandom), 16'($urandom), 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Fetch request cycle, then the cycle in which the RAM returns the word.
  task automatic gen_fw(input logic [31:0] word);
    push($urandom, 1'($urandom), 16'($urandom), 1'b1, 1'b0, m_instr, 1'b0);
    push(word, 1'($urandom), 16'($urandom), 1'b0, 1'b0, m_instr, 1'b0);
  endtask

  task automatic gen_exec(input logic [31:0] word, input logic bv, input logic [15:0] bt);
    logic [3:0] op;
    m_instr = word;
    op = word[31:28];
    push($urandom, bv, bt, 1'b0, 1'b1, word, 1'b0);
    m_pc = bv ? bt : m_pc + 16'd1;
    if (op == 4'hD || op == 4'hE)
      push($urandom, 1'($urandom), 16'($urandom), 1'b0, 1'b1, word, 1'b0);
  endtask

  task automatic gen_instr(input logic [31:0] word, input logic bv, input logic [15:0] bt);
    gen_fw(word);
    gen_exec(word, bv, bt);
  endtask

  task automatic gen_halt(input int n);
    for (int i = 0; i < n; i++)
      push($urandom, 1'($urandom), 16'($urandom), 1'b0, 1'b0, m_instr, 1'b1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, ".fetch_req"},   32'(fetch_req),   32'h0);
    check({pfx, ".fetch_addr"},  32'(fetch_addr),  32'h0);
    check({pfx, ".instr"},       instr,            32'h0);
    check({pfx, ".instr_valid"}, 32'(instr_valid), 32'h0);
    check({pfx, ".opcode"},      32'(opcode),      32'h0);
    check({pfx, ".halted"},      32'(halted),      32'h0);
  endtask

  // Hold reset across an edge, check reset values, release just after a rising edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    @(negedge clock);
    check_zero("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    m_pc    = 16'h0000;
    m_instr = 32'h0;
  endtask

  // Plays the script starting in the cycle right after reset release.
  task automatic run_script();
    cyc_t c;
    int   i;
    i = 0;
    while (script.size() > 0) begin
      c = script.pop_front();
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      ram_data      = c.ram;
      branch_valid  = c.bv;
      branch_target = c.bt;
      @(negedge clock);
      check($sformatf("c%0d.fetch_req", cyc_no),   32'(fetch_req),   32'(c.req));
      check($sformatf("c%0d.fetch_addr", cyc_no),  32'(fetch_addr),  32'(c.addr));
      check($sformatf("c%0d.instr_valid", cyc_no), 32'(instr_valid), 32'(c.valid));
      check($sformatf("c%0d.instr", cyc_no),       instr,            c.ins);
      check($sformatf("c%0d.opcode", cyc_no),      32'(opcode),      32'(c.ins[31:28]));
      check($sformatf("c%0d.halted", cyc_no),      32'(halted),      32'(c.halt));
      i++;
      cyc_no++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic        bv;
    logic [15:0] bt;
    reset_n       = 1'b0;
    ram_data      = 32'h0;
    branch_valid  = 1'b0;
    branch_target = 16'h0;
    m_pc          = 16'h0;
    m_instr       = 32'h0;

    // Directed start-up, LDR, branch, wrap and STR, then random traffic ending in HALT.
    do_reset();
    gen_idle();
    gen_instr(32'h1000_0000, 1'b0, 16'h0);
    gen_instr(32'hD000_0000, 1'b0, 16'h0);
    gen_instr(32'h2345_6789, 1'b1, 16'h0040);
    gen_instr(32'h3000_0001, 1'b0, 16'h0);
    gen_instr(32'h4000_0002, 1'b1, 16'hFFFF);
    gen_instr(32'h5000_0003, 1'b0, 16'h0);
    gen_instr(32'hE000_0004, 1'b0, 16'h0);
    for (int k = 0; k < 150; k++) begin
      bv = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      gen_instr(rand_word(), bv, bt);
    end
    gen_instr(32'hF000_0000, 1'b0, 16'h0);
    gen_halt(20);
    run_script();

    // Reset out of HALT restarts at address 0; then reset lands mid-WAIT.
    do_reset();
    gen_idle();
    gen_instr(32'h6ABC_DEF0, 1'b0, 16'h0);
    gen_instr(32'hD123_4567, 1'b0, 16'h0);
    gen_instr(rand_word(), 1'b0, 16'h0);
    gen_fw(32'h7777_0000);
    run_script();
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async");

    do_reset();
    gen_idle();
    gen_instr(32'h8000_0001, 1'b0, 16'h0);
    gen_instr(32'hE000_0002, 1'b1, 16'h0100);
    gen_instr(32'hF000_0003, 1'b1, 16'h1234);
    gen_halt(5);
    run_script();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
